pipelined_control_unit: RTL and testbench

//  Decodes the ID-stage opcode/funct of the MIPS pipeline into a control word and carries it

---
 rtl/pipelined_control_unit.sv | 213 +++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// Purpose: decodes the ID-stage opcode/funct and carries the control word through the ID/EX, EX/MEM and MEM/WB stage registers.
// Latency: decode is combinational; the word appears on ex_* after 1 cycle, on mem_* after 2 cycles and on wb_* after 3 cycles.
// Backpressure: ena=0 freezes all state. A load-use hazard holds PC and IF/ID for one cycle and injects a bubble. A taken branch flushes IF/ID and ID/EX.
module pipelined_control_unit #(
    parameter int OP_W      = 6,
    parameter int FN_W      = 6,
    parameter int RA_W      = 5,
    parameter int CNT_W     = 8,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [OP_W-1:0]  id_opcode,
    input  logic [FN_W-1:0]  id_funct,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             ex_reg_dst,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_branch,
    output logic             ex_mem_to_reg,
    output logic             ex_reg_write,
    output logic [FN_W-1:0]  ex_alu_op,
    output logic [RA_W-1:0]  ex_rt,
    output logic [RA_W-1:0]  ex_wreg,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             mem_mem_to_reg,
    output logic             mem_reg_write,
    output logic [RA_W-1:0]  mem_wreg,
    output logic             wb_mem_to_reg,
    output logic             wb_reg_write,
    output logic [RA_W-1:0]  wb_wreg,
    output logic             illegal_op,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [FN_W-1:0] ALU_ADD = FN_W'(6'b100000);
    localparam logic [FN_W-1:0] ALU_SUB = FN_W'(6'b100010);

    typedef struct packed {
        logic            reg_dst;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            mem_to_reg;
        logic            reg_write;
        logic [FN_W-1:0] alu_op;
        logic [RA_W-1:0] rt;
        logic [RA_W-1:0] wreg;
    } idex_t;

    typedef struct packed {
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            reg_write;
        logic [RA_W-1:0] wreg;
    } exmem_t;

    typedef struct packed {
        logic            mem_to_reg;
        logic            reg_write;
        logic [RA_W-1:0] wreg;
    } memwb_t;

    idex_t            dec;
    logic             dec_illegal;
    idex_t            ex_q;
    exmem_t           mem_q;
    memwb_t           wb_q;
    logic             illegal_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             stall;

    // Decode: undefined opcodes produce an all-zero word (register fields included).
    // Writes to register 0 are suppressed.
    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        case (id_opcode)
            OP_R: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = id_funct;
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (!dec_illegal) begin
            dec.rt   = id_rt;
            dec.wreg = dec.reg_dst ? id_rd : id_rt;
        end
        if (dec.wreg == '0) begin
            dec.reg_write = 1'b0;
        end
    end

    // Load-use hazard: the load in EX targets a register read by the instruction in ID.
    assign stall = HAZARD_EN && ex_q.mem_read && (ex_q.rt != '0) &&
                   ((ex_q.rt == id_rs) || (ex_q.rt == id_rt));

    // Stage registers: a flush or stall injects a bubble into ID/EX.
    // The later stages always advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            illegal_q <= 1'b0;
        end else if (ena) begin
            mem_q.mem_read   <= ex_q.mem_read;
            mem_q.mem_write  <= ex_q.mem_write;
            mem_q.mem_to_reg <= ex_q.mem_to_reg;
            mem_q.reg_write  <= ex_q.reg_write;
            mem_q.wreg       <= ex_q.wreg;
            wb_q.mem_to_reg  <= mem_q.mem_to_reg;
            wb_q.reg_write   <= mem_q.reg_write;
            wb_q.wreg        <= mem_q.wreg;
            if (branch_taken || stall) begin
                ex_q      <= '0;
                illegal_q <= 1'b0;
            end else begin
                ex_q      <= dec;
                illegal_q <= dec_illegal;
            end
        end
    end

    // Saturating count of cycles actually spent stalled.
    // A stall is not counted when a flush overrides it in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (ena && !branch_taken && stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // PC / IF-ID enables, in priority order: reset, freeze, flush, stall, normal.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        if (rst) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
        end else if (!ena) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end
    end

    assign ex_reg_dst     = ex_q.reg_dst;
    assign ex_alu_src     = ex_q.alu_src;
    assign ex_mem_read    = ex_q.mem_read;
    assign ex_mem_write   = ex_q.mem_write;
    assign ex_branch      = ex_q.branch;
    assign ex_mem_to_reg  = ex_q.mem_to_reg;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_alu_op      = ex_q.alu_op;
    assign ex_rt          = ex_q.rt;
    assign ex_wreg        = ex_q.wreg;
    assign mem_mem_read   = mem_q.mem_read;
    assign mem_mem_write  = mem_q.mem_write;
    assign mem_mem_to_reg = mem_q.mem_to_reg;
    assign mem_reg_write  = mem_q.reg_write;
    assign mem_wreg       = mem_q.wreg;
    assign wb_mem_to_reg  = wb_q.mem_to_reg;
    assign wb_reg_write   = wb_q.reg_write;
    assign wb_wreg        = wb_q.wreg;
    assign illegal_op     = illegal_q;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Purpose: directed vector bench for pipelined_control_unit.
// Latency: one vector per clock; combinational enables are sampled before the edge, registered outputs 1 ns after it.
// Backpressure: includes a freeze (ena=0) window, flushes, stalls and saturation of the stall counter.
module tb_pipelined_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [5:0] id_opcode = '0;
    logic [5:0] id_funct = '0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic [4:0] id_rd = '0;
    logic       branch_taken = 1'b0;
    logic       pc_write, if_id_write, if_id_flush;
    logic       ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg, ex_reg_write;
    logic [5:0] ex_alu_op;
    logic [4:0] ex_rt, ex_wreg;
    logic       mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
    logic [4:0] mem_wreg;
    logic       wb_mem_to_reg, wb_reg_write;
    logic [4:0] wb_wreg;
    logic       illegal_op;
    logic [7:0] stall_cnt;

    pipelined_control_unit dut (
        .clk(clk), .rst(rst), .ena(ena),
        .id_opcode(id_opcode), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .branch_taken(branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_reg_write(mem_reg_write), .mem_wreg(mem_wreg),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg),
        .illegal_op(illegal_op), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Expected 7-bit control fields:
    // {reg_dst, alu_src, mem_read, mem_write, branch, mem_to_reg, reg_write}
    localparam logic [6:0] C_R    = 7'b1000001;
    localparam logic [6:0] C_LW   = 7'b0110011;
    localparam logic [6:0] C_LW0  = 7'b0110010;
    localparam logic [6:0] C_SW   = 7'b0101000;
    localparam logic [6:0] C_BEQ  = 7'b0000100;
    localparam logic [6:0] C_ADDI = 7'b0100001;

    typedef struct {
        logic        rst, ena, bt;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic [2:0]  ctl;   // {pc_write, if_id_write, if_id_flush} before the edge
        logic [22:0] ex;    // {ctl7, alu_op, rt, wreg}
        logic [8:0]  mem;   // {mem_read, mem_write, mem_to_reg, reg_write, wreg}
        logic [6:0]  wb;    // {mem_to_reg, reg_write, wreg}
        logic        ill;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [22:0] ex_act;
    logic [8:0]  mem_act;
    logic [6:0]  wb_act;
    assign ex_act  = {ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg,
                      ex_reg_write, ex_alu_op, ex_rt, ex_wreg};
    assign mem_act = {mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_wreg};
    assign wb_act  = {wb_mem_to_reg, wb_reg_write, wb_wreg};

    task automatic add(input logic r, input logic e, input logic b,
                       input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [2:0] ctl, input logic [22:0] ex, input logic [8:0] mem,
                       input logic [6:0] wb, input logic ill, input logic [7:0] cnt);
        vec_t v;
        v.rst = r; v.ena = e; v.bt = b; v.op = op; v.fn = fn; v.rs = rs; v.rt = rt; v.rd = rd;
        v.ctl = ctl; v.ex = ex; v.mem = mem; v.wb = wb; v.ill = ill; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n_low;
        // rst, ena, bt, op, fn, rs, rt, rd, ctl, ex, mem, wb, ill, cnt
        add(1, 1, 0, 6'h00, 6'h20,  1,  2,  3, 3'b110, 23'd0, 9'd0, 7'd0, 0, 8'd0);
        add(0, 1, 0, 6'h23, 6'h00, 16,  8,  0, 3'b110, {C_LW, 6'h20, 5'd8, 5'd8}, 9'd0, 7'd0, 0, 8'd0);
        add(0, 1, 0, 6'h00, 6'h20,  8, 10,  9, 3'b000, 23'd0, {4'b1011, 5'd8}, 7'd0, 0, 8'd1);
        add(0, 1, 0, 6'h00, 6'h20,  8, 10,  9, 3'b110, {C_R, 6'h20, 5'd10, 5'd9}, 9'd0, {2'b11, 5'd8}, 0, 8'd1);
        add(0, 1, 0, 6'h23, 6'h00, 16,  0,  0, 3'b110, {C_LW0, 6'h20, 5'd0, 5'd0}, {4'b0001, 5'd9}, 7'd0, 0, 8'd1);
        add(0, 1, 0, 6'h00, 6'h20,  0,  0, 11, 3'b110, {C_R, 6'h20, 5'd0, 5'd11}, {4'b1010, 5'd0}, {2'b01, 5'd9}, 0, 8'd1);
        add(0, 1, 0, 6'h2B, 6'h00, 16, 10,  0, 3'b110, {C_SW, 6'h20, 5'd10, 5'd10}, {4'b0001, 5'd11}, {2'b10, 5'd0}, 0, 8'd1);
        add(0, 1, 0, 6'h23, 6'h00, 16,  8,  0, 3'b110, {C_LW, 6'h20, 5'd8, 5'd8}, {4'b0100, 5'd10}, {2'b01, 5'd11}, 0, 8'd1);
        add(0, 1, 1, 6'h00, 6'h20,  8, 10,  9, 3'b111, 23'd0, {4'b1011, 5'd8}, {2'b00, 5'd10}, 0, 8'd1);
        add(0, 1, 0, 6'h04, 6'h00,  9, 10,  0, 3'b110, {C_BEQ, 6'h22, 5'd10, 5'd10}, 9'd0, {2'b11, 5'd8}, 0, 8'd1);
        add(0, 0, 0, 6'h08, 6'h00,  8,  9,  0, 3'b000, {C_BEQ, 6'h22, 5'd10, 5'd10}, 9'd0, {2'b11, 5'd8}, 0, 8'd1);
        add(0, 0, 1, 6'h3F, 6'h00,  1,  2,  3, 3'b000, {C_BEQ, 6'h22, 5'd10, 5'd10}, 9'd0, {2'b11, 5'd8}, 0, 8'd1);
        add(0, 0, 0, 6'h08, 6'h00,  8,  9,  0, 3'b000, {C_BEQ, 6'h22, 5'd10, 5'd10}, 9'd0, {2'b11, 5'd8}, 0, 8'd1);
        add(0, 1, 0, 6'h08, 6'h00,  8,  9,  0, 3'b110, {C_ADDI, 6'h20, 5'd9, 5'd9}, {4'b0000, 5'd10}, 7'd0, 0, 8'd1);
        add(0, 1, 0, 6'h3F, 6'h00,  1,  2,  3, 3'b110, 23'd0, {4'b0001, 5'd9}, {2'b00, 5'd10}, 1, 8'd1);
        add(0, 1, 0, 6'h00, 6'h22,  1,  2,  3, 3'b110, {C_R, 6'h22, 5'd2, 5'd3}, 9'd0, {2'b01, 5'd9}, 0, 8'd1);
        add(0, 1, 1, 6'h3F, 6'h00,  1,  2,  3, 3'b111, 23'd0, {4'b0001, 5'd3}, 7'd0, 0, 8'd1);
        add(0, 1, 0, 6'h23, 6'h00, 16,  8,  0, 3'b110, {C_LW, 6'h20, 5'd8, 5'd8}, 9'd0, {2'b01, 5'd3}, 0, 8'd1);
        add(0, 1, 0, 6'h00, 6'h20,  8, 10,  9, 3'b000, 23'd0, {4'b1011, 5'd8}, 7'd0, 0, 8'd2);
        add(1, 1, 0, 6'h00, 6'h20,  8, 10,  9, 3'b110, 23'd0, 9'd0, 7'd0, 0, 8'd0);
        add(0, 1, 0, 6'h00, 6'h20,  8, 10,  9, 3'b110, {C_R, 6'h20, 5'd10, 5'd9}, 9'd0, 7'd0, 0, 8'd0);
        add(0, 1, 0, 6'h23, 6'h00, 16,  8,  0, 3'b110, {C_LW, 6'h20, 5'd8, 5'd8}, {4'b0001, 5'd9}, 7'd0, 0, 8'd0);
        add(0, 1, 0, 6'h2B, 6'h00, 16,  8,  0, 3'b000, 23'd0, {4'b1011, 5'd8}, {2'b01, 5'd9}, 0, 8'd1);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst; ena = vq[i].ena; branch_taken = vq[i].bt;
            id_opcode = vq[i].op; id_funct = vq[i].fn;
            id_rs = vq[i].rs; id_rt = vq[i].rt; id_rd = vq[i].rd;
            #1;
            check("ctl", i, 32'({pc_write, if_id_write, if_id_flush}), 32'(vq[i].ctl));
            @(posedge clk);
            #1;
            check("ex",        i, 32'(ex_act),     32'(vq[i].ex));
            check("mem",       i, 32'(mem_act),    32'(vq[i].mem));
            check("wb",        i, 32'(wb_act),     32'(vq[i].wb));
            check("illegal",   i, 32'(illegal_op), 32'(vq[i].ill));
            check("stall_cnt", i, 32'(stall_cnt),  32'(vq[i].cnt));
        end

        // Asynchronous reset asserted mid-cycle, while a load-use stall condition is pending.
        @(negedge clk);
        rst = 1'b0; ena = 1'b1; branch_taken = 1'b0;
        id_opcode = 6'h23; id_funct = 6'h00; id_rs = 5'd16; id_rt = 5'd8; id_rd = 5'd0;
        @(posedge clk);
        #1;
        check("ld_in_ex", 100, 32'(ex_mem_read), 32'd1);
        @(negedge clk);
        id_opcode = 6'h00; id_funct = 6'h20; id_rs = 5'd8; id_rt = 5'd10; id_rd = 5'd9;
        #1;
        check("pre_rst_stall", 101, 32'(pc_write), 32'd0);
        rst = 1'b1;
        #1;
        check("async_rst_ex", 102, 32'(ex_act), 32'd0);
        check("async_rst_pc", 103, 32'({pc_write, if_id_write, if_id_flush}), 32'b110);
        check("async_rst_cnt", 104, 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Repeated LW $t0,0($t0) stalls on itself every other cycle: 300 stalls in 600 cycles.
        id_opcode = 6'h23; id_funct = 6'h00; id_rs = 5'd8; id_rt = 5'd8; id_rd = 5'd0;
        n_low = 0;
        for (int c = 0; c < 600; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (!pc_write) n_low++;
            @(posedge clk);
        end
        #1;
        check("stall_cycles", 105, 32'(n_low), 32'd300);
        check("stall_sat", 106, 32'(stall_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
